datapath_regfile: RTL and testbench
===================================

Name: datapath_regfile

Overview:
- Register-file and bus datapath directly downstream of the processor control FSM.
- Consumes its per-state control word (bflag, alu, cflag, increment strobes, fetch) and executes it on the registers AR, PC, R1, R2, R3, R, AC and IR.
- Drives the IRAM and DRAM address, data and write-enable lines.
- Returns the instruction byte (ir) and zero flag (z) to the FSM.

Parameters:
- DATA_W, 8, width of all data registers, B bus and ALU.
- ADDR_W, 8, width of AR and PC, and of the DRAM and IRAM addresses.

Ports:
- clk  in  1  system clock; all registers update on posedge (the FSM changes state on negedge).
- rst_n  in  1  synchronous active-low reset, sampled on posedge clk.
- pcinc  in  1  PC <= PC+1.
- r1inc  in  1  R1 <= R1+1.
- r2inc  in  1  R2 <= R2+1.
- r3inc  in  1  R3 <= R3+1.
- acinc  in  1  AC <= AC+1.
- fetch  in  1  IR <= B bus.
- alu  in  3  ALU operation.
- bflag  in  3  B-bus source select.
- cflag  in  8  write enables; bit7 AR, bit6 PC, bit5 R1, bit4 R2, bit3 R3, bit2 R, bit1 AC, bit0 DRAM write.
- iram_data  in  DATA_W  IRAM read data.
- dram_rdata  in  DATA_W  DRAM read data.
- iram_addr  out  ADDR_W  equals PC.
- dram_addr  out  ADDR_W  equals AR.
- dram_wdata  out  DATA_W  equals B bus.
- dram_we  out  1  equals cflag[0].
- ir  out  DATA_W  instruction register.
- z  out  1  1 when AC == 0.
- bus_out  out  DATA_W  current B bus value (debug/verification).

Behaviour:
- Reset: while rst_n=0 at posedge, AR, PC, R1, R2, R3, R, AC and IR all load 0. z therefore reads 1 after reset. Reset mid-instruction discards any pending write or increment in that cycle.
- B bus mux (combinational) by bflag:
  - 0: dram_rdata
  - 1: constant 0
  - 2: R1
  - 3: R2
  - 4: R3
  - 5: R
  - 6: AC
  - 7: iram_data
- ALU (combinational, result C, modulo 2^DATA_W, no carry out):
  - 0: AC+B
  - 1: AC-B
  - 2: B
  - 3: 0
  - 4: AC-1
  - 5: AC<<2 (zero fill)
  - 6: AC>>1 (logical)
  - 7: AC (hold)
- Register writes at posedge:
  - AC loads C when cflag[1]=1.
  - AR, PC, R1, R2, R3 and R load the B bus directly (not C) when their cflag bit is 1.
  - IR loads the B bus when fetch=1.
- Increments (+1 mod 2^width) happen at posedge when the corresponding inc strobe is 1.
  - If an inc and a cflag write target the same register in one cycle, the write wins and the increment is dropped.
  - Simultaneous increments on different registers are independent.
- Wrap-around: PC = 2^ADDR_W-1 with pcinc wraps to 0. AC = 0 with alu=4 gives all-ones.
- dram_we, dram_wdata and dram_addr are combinational pass-throughs, so DRAM samples them on its own posedge. AR written in a cycle affects dram_addr only from the next cycle.
- z is combinational from the AC register (not from C) and is valid one cycle after any AC update.
- Latency: every control word takes effect at the first posedge after it is presented; there is no internal pipelining.
- Multiple cflag bits set simultaneously: all selected registers load in the same cycle; this is legal.
- Unused/undefined inputs: none. All bflag and alu encodings are defined.

Decomposition:
- Shared package proc_pkg holds:
  - bflag encodings (B_DRAM, B_ZERO, B_R1, B_R2, B_R3, B_R, B_AC, B_IRAM)
  - alu encodings (ALU_ADD, ALU_SUB, ALU_PASS, ALU_CLR, ALU_DEC, ALU_MUL4, ALU_DIV2, ALU_HOLD)
  - cflag bit indices (C_AR … C_M)
  - The control FSM imports the same package.
- One sub-module: datapath_alu, the purely combinational ALU. The register file and bus mux stay in the top.

Test Plan:
- Reset with all registers preloaded nonzero; hold rst_n=0 for one posedge → all registers 0, z=1, iram_addr=0.
- iram_data=8'h13, fetch=1, pcinc=1, bflag=7 for one cycle → IR=8'h13, PC=1. Repeat at PC=8'hFF → PC wraps to 0.
- R=8'h05, AC=8'h03, alu=0, bflag=5, cflag=8'h02 → AC=8'h08, z=0. Then alu=1 with R=8'h08 → AC=0, z=1 next cycle.
- Shift ops: AC=8'h41, alu=5, bflag=6, cflag=8'h02 → AC=8'h04. Then AC=8'h81, alu=6 → AC=8'h40.
- Store/load: AC=8'h2A, bflag=6, cflag=8'h80 → AR=8'h2A. Next cycle bflag=6, cflag=8'h01 → dram_we=1, dram_addr=8'h2A, dram_wdata=8'h2A. Then dram_rdata=8'h77, bflag=0, alu=2, cflag=8'h02 → AC=8'h77.
- Conflict: R1=8'h10, r1inc=1 and cflag[5]=1 with bflag=6, AC=8'h55 → R1=8'h55 (write wins). Next cycle r1inc=1 alone → R1=8'h56.

Source files
------------

// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared encodings for the processor control word
package proc_pkg;

    typedef enum logic [2:0] {
        B_DRAM = 3'd0,
        B_ZERO = 3'd1,
        B_R1   = 3'd2,
        B_R2   = 3'd3,
        B_R3   = 3'd4,
        B_R    = 3'd5,
        B_AC   = 3'd6,
        B_IRAM = 3'd7
    } bsel_e;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_PASS = 3'd2,
        ALU_CLR  = 3'd3,
        ALU_DEC  = 3'd4,
        ALU_MUL4 = 3'd5,
        ALU_DIV2 = 3'd6,
        ALU_HOLD = 3'd7
    } alu_e;

    // Bit positions inside cflag.
    localparam int C_AR = 7;
    localparam int C_PC = 6;
    localparam int C_R1 = 5;
    localparam int C_R2 = 4;
    localparam int C_R3 = 3;
    localparam int C_R  = 2;
    localparam int C_AC = 1;
    localparam int C_M  = 0;

endpackage

// File: rtl/datapath_alu.sv
// rtl/datapath_alu.sv - combinational ALU operating on AC and the B bus
module datapath_alu
    import proc_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] ac,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] c
);

    always_comb begin
        c = ac;
        case (op)
            ALU_ADD:  c = ac + b;
            ALU_SUB:  c = ac - b;
            ALU_PASS: c = b;
            ALU_CLR:  c = '0;
            ALU_DEC:  c = ac - DATA_W'(1);
            ALU_MUL4: c = ac << 2;
            ALU_DIV2: c = ac >> 1;
            ALU_HOLD: c = ac;
            default:  c = ac;
        endcase
    end

endmodule

// File: rtl/datapath_regfile.sv
// rtl/datapath_regfile.sv - register file, B bus mux and memory interface
module datapath_regfile
    import proc_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pcinc,
    input  logic              r1inc,
    input  logic              r2inc,
    input  logic              r3inc,
    input  logic              acinc,
    input  logic              fetch,
    input  logic [2:0]        alu,
    input  logic [2:0]        bflag,
    input  logic [7:0]        cflag,
    input  logic [DATA_W-1:0] iram_data,
    input  logic [DATA_W-1:0] dram_rdata,
    output logic [ADDR_W-1:0] iram_addr,
    output logic [ADDR_W-1:0] dram_addr,
    output logic [DATA_W-1:0] dram_wdata,
    output logic              dram_we,
    output logic [DATA_W-1:0] ir,
    output logic              z,
    output logic [DATA_W-1:0] bus_out
);

    logic [ADDR_W-1:0] ar_q, pc_q;
    logic [DATA_W-1:0] r1_q, r2_q, r3_q, r_q, ac_q, ir_q;
    logic [DATA_W-1:0] bus, alu_c;

    always_comb begin
        bus = '0;
        case (bflag)
            B_DRAM:  bus = dram_rdata;
            B_ZERO:  bus = '0;
            B_R1:    bus = r1_q;
            B_R2:    bus = r2_q;
            B_R3:    bus = r3_q;
            B_R:     bus = r_q;
            B_AC:    bus = ac_q;
            B_IRAM:  bus = iram_data;
            default: bus = '0;
        endcase
    end

    datapath_alu #(.DATA_W(DATA_W)) u_alu (
        .op (alu),
        .ac (ac_q),
        .b  (bus),
        .c  (alu_c)
    );

    // A cflag write takes priority over an increment on the same register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ar_q <= '0;
            pc_q <= '0;
            r1_q <= '0;
            r2_q <= '0;
            r3_q <= '0;
            r_q  <= '0;
            ac_q <= '0;
            ir_q <= '0;
        end else begin
            if (cflag[C_AR]) ar_q <= ADDR_W'(bus);

            if (cflag[C_PC])  pc_q <= ADDR_W'(bus);
            else if (pcinc)   pc_q <= pc_q + ADDR_W'(1);

            if (cflag[C_R1])  r1_q <= bus;
            else if (r1inc)   r1_q <= r1_q + DATA_W'(1);

            if (cflag[C_R2])  r2_q <= bus;
            else if (r2inc)   r2_q <= r2_q + DATA_W'(1);

            if (cflag[C_R3])  r3_q <= bus;
            else if (r3inc)   r3_q <= r3_q + DATA_W'(1);

            if (cflag[C_R])   r_q <= bus;

            if (cflag[C_AC])  ac_q <= alu_c;
            else if (acinc)   ac_q <= ac_q + DATA_W'(1);

            if (fetch) ir_q <= bus;
        end
    end

    assign iram_addr  = pc_q;
    assign dram_addr  = ar_q;
    assign dram_wdata = bus;
    assign dram_we    = cflag[C_M];
    assign ir         = ir_q;
    assign z          = (ac_q == '0);
    assign bus_out    = bus;

endmodule

// File: tb/tb_datapath_regfile.sv
// tb/tb_datapath_regfile.sv - scoreboard bench for datapath_regfile
module tb_datapath_regfile;
    import proc_pkg::*;

    typedef struct packed {
        logic [7:0] ar, pc, r1, r2, r3, r, ac, ir;
    } regs_t;

    logic       clk = 1'b0;
    logic       rst_n, pcinc, r1inc, r2inc, r3inc, acinc, fetch, dram_we, z;
    logic [2:0] alu, bflag;
    logic [7:0] cflag, iram_data, dram_rdata, iram_addr, dram_addr, dram_wdata, ir, bus_out;

    int    checks = 0;
    int    failures = 0;
    regs_t m = '0;
    regs_t sb[$];

    always #5 clk = ~clk;

    datapath_regfile #(.DATA_W(8), .ADDR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .pcinc(pcinc), .r1inc(r1inc), .r2inc(r2inc),
        .r3inc(r3inc), .acinc(acinc), .fetch(fetch), .alu(alu), .bflag(bflag),
        .cflag(cflag), .iram_data(iram_data), .dram_rdata(dram_rdata),
        .iram_addr(iram_addr), .dram_addr(dram_addr), .dram_wdata(dram_wdata),
        .dram_we(dram_we), .ir(ir), .z(z), .bus_out(bus_out)
    );

    task automatic idle();
        rst_n = 1'b1; pcinc = 1'b0; r1inc = 1'b0; r2inc = 1'b0; r3inc = 1'b0;
        acinc = 1'b0; fetch = 1'b0; alu = ALU_HOLD; bflag = B_ZERO; cflag = 8'h00;
    endtask

    // Reference behaviour of one posedge, written independently of the RTL.
    function automatic regs_t model_next(input regs_t s, input logic rst, input logic [2:0] b,
                                         input logic [2:0] a, input logic [7:0] cf,
                                         input logic [4:0] inc, input logic f,
                                         input logic [7:0] id, input logic [7:0] dd);
        regs_t n = s;
        logic [7:0] bv, cv;
        if (!rst) return '0;
        bv = (b == 3'd0) ? dd : (b == 3'd1) ? 8'h00 : (b == 3'd2) ? s.r1 : (b == 3'd3) ? s.r2 :
             (b == 3'd4) ? s.r3 : (b == 3'd5) ? s.r  : (b == 3'd6) ? s.ac : id;
        case (a)
            3'd0: cv = 8'((s.ac + bv) % 256);
            3'd1: cv = 8'((s.ac + 256 - bv) % 256);
            3'd2: cv = bv;
            3'd3: cv = 8'h00;
            3'd4: cv = 8'((s.ac + 255) % 256);
            3'd5: cv = {s.ac[5:0], 2'b00};
            3'd6: cv = {1'b0, s.ac[7:1]};
            default: cv = s.ac;
        endcase
        n.pc = inc[4] ? 8'((s.pc + 1) % 256) : s.pc;
        n.r1 = inc[3] ? 8'((s.r1 + 1) % 256) : s.r1;
        n.r2 = inc[2] ? 8'((s.r2 + 1) % 256) : s.r2;
        n.r3 = inc[1] ? 8'((s.r3 + 1) % 256) : s.r3;
        n.ac = inc[0] ? 8'((s.ac + 1) % 256) : s.ac;
        if (cf[7]) n.ar = bv;
        if (cf[6]) n.pc = bv;
        if (cf[5]) n.r1 = bv;
        if (cf[4]) n.r2 = bv;
        if (cf[3]) n.r3 = bv;
        if (cf[2]) n.r  = bv;
        if (cf[1]) n.ac = cv;
        if (f)     n.ir = bv;
        return n;
    endfunction

    // inc = {pcinc, r1inc, r2inc, r3inc, acinc}
    task automatic drive(input logic rst, input logic [2:0] b, input logic [2:0] a,
                         input logic [7:0] cf, input logic [4:0] inc, input logic f,
                         input logic [7:0] id, input logic [7:0] dd);
        rst_n = rst; bflag = b; alu = a; cflag = cf; fetch = f;
        {pcinc, r1inc, r2inc, r3inc, acinc} = inc;
        iram_data = id; dram_rdata = dd;
        #1;
        m = model_next(m, rst, b, a, cf, inc, f, id, dd);
        sb.push_back(m);
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic peek(input logic [2:0] sel, output logic [7:0] v);
        bflag = sel;
        #1;
        v = bus_out;
        bflag = B_ZERO;
    endtask

    task automatic test_reset();
        regs_t e;
        logic [7:0] v;
        drive(1'b1, B_IRAM, ALU_PASS, 8'hFE, 5'b00000, 1'b1, 8'hA5, 8'h00);
        e = sb.pop_front();
        checks++; if (ir !== e.ir) begin failures++; $display("FAIL preload_ir actual=%h expected=%h", ir, e.ir); end
        peek(B_AC, v);
        checks++; if (v !== e.ac) begin failures++; $display("FAIL preload_ac actual=%h expected=%h", v, e.ac); end
        drive(1'b0, B_IRAM, ALU_PASS, 8'hFE, 5'b11111, 1'b1, 8'h5A, 8'h00);
        e = sb.pop_front();
        checks++; if (ir !== 8'h00) begin failures++; $display("FAIL reset_ir actual=%h expected=00", ir); end
        checks++; if (iram_addr !== e.pc) begin failures++; $display("FAIL reset_pc actual=%h expected=%h", iram_addr, e.pc); end
        checks++; if (dram_addr !== e.ar) begin failures++; $display("FAIL reset_ar actual=%h expected=%h", dram_addr, e.ar); end
        checks++; if (z !== 1'b1) begin failures++; $display("FAIL reset_z actual=%b expected=1", z); end
        peek(B_R1, v);
        checks++; if (v !== e.r1) begin failures++; $display("FAIL reset_r1 actual=%h expected=%h", v, e.r1); end
        peek(B_R, v);
        checks++; if (v !== e.r) begin failures++; $display("FAIL reset_r actual=%h expected=%h", v, e.r); end
    endtask

    task automatic test_fetch();
        regs_t e;
        drive(1'b1, B_IRAM, ALU_HOLD, 8'h00, 5'b10000, 1'b1, 8'h13, 8'h00);
        e = sb.pop_front();
        checks++; if (ir !== e.ir) begin failures++; $display("FAIL fetch_ir actual=%h expected=%h", ir, e.ir); end
        checks++; if (iram_addr !== e.pc) begin failures++; $display("FAIL fetch_pc actual=%h expected=%h", iram_addr, e.pc); end
        drive(1'b1, B_IRAM, ALU_HOLD, 8'h40, 5'b00000, 1'b0, 8'hFF, 8'h00);
        e = sb.pop_front();
        checks++; if (iram_addr !== e.pc) begin failures++; $display("FAIL load_pc actual=%h expected=%h", iram_addr, e.pc); end
        drive(1'b1, B_IRAM, ALU_HOLD, 8'h00, 5'b10000, 1'b1, 8'h22, 8'h00);
        e = sb.pop_front();
        checks++; if (iram_addr !== 8'h00 || iram_addr !== e.pc) begin failures++; $display("FAIL pc_wrap actual=%h expected=%h", iram_addr, e.pc); end
        checks++; if (ir !== e.ir) begin failures++; $display("FAIL wrap_ir actual=%h expected=%h", ir, e.ir); end
    endtask

    task automatic test_add_sub();
        regs_t e;
        logic [7:0] v;
        drive(1'b1, B_IRAM, ALU_HOLD, 8'h04, 5'b00000, 1'b0, 8'h05, 8'h00);
        drive(1'b1, B_IRAM, ALU_PASS, 8'h02, 5'b00000, 1'b0, 8'h03, 8'h00);
        drive(1'b1, B_R, ALU_ADD, 8'h02, 5'b00000, 1'b0, 8'h00, 8'h00);
        void'(sb.pop_front()); void'(sb.pop_front());
        e = sb.pop_front();
        peek(B_AC, v);
        checks++; if (v !== e.ac) begin failures++; $display("FAIL add_ac actual=%h expected=%h", v, e.ac); end
        checks++; if (z !== 1'b0) begin failures++; $display("FAIL add_z actual=%b expected=0", z); end
        drive(1'b1, B_IRAM, ALU_HOLD, 8'h04, 5'b00000, 1'b0, 8'h08, 8'h00);
        drive(1'b1, B_R, ALU_SUB, 8'h02, 5'b00000, 1'b0, 8'h00, 8'h00);
        void'(sb.pop_front());
        e = sb.pop_front();
        peek(B_AC, v);
        checks++; if (v !== e.ac) begin failures++; $display("FAIL sub_ac actual=%h expected=%h", v, e.ac); end
        checks++; if (z !== 1'b1) begin failures++; $display("FAIL sub_z actual=%b expected=1", z); end
        drive(1'b1, B_ZERO, ALU_DEC, 8'h02, 5'b00000, 1'b0, 8'h00, 8'h00);
        e = sb.pop_front();
        peek(B_AC, v);
        checks++; if (v !== e.ac) begin failures++; $display("FAIL dec_wrap actual=%h expected=%h", v, e.ac); end
    endtask

    task automatic test_shift();
        regs_t e;
        logic [7:0] v;
        drive(1'b1, B_IRAM, ALU_PASS, 8'h02, 5'b00000, 1'b0, 8'h41, 8'h00);
        drive(1'b1, B_AC, ALU_MUL4, 8'h02, 5'b00000, 1'b0, 8'h00, 8'h00);
        void'(sb.pop_front());
        e = sb.pop_front();
        peek(B_AC, v);
        checks++; if (v !== e.ac) begin failures++; $display("FAIL mul4 actual=%h expected=%h", v, e.ac); end
        drive(1'b1, B_IRAM, ALU_PASS, 8'h02, 5'b00000, 1'b0, 8'h81, 8'h00);
        drive(1'b1, B_AC, ALU_DIV2, 8'h02, 5'b00000, 1'b0, 8'h00, 8'h00);
        void'(sb.pop_front());
        e = sb.pop_front();
        peek(B_AC, v);
        checks++; if (v !== e.ac) begin failures++; $display("FAIL div2 actual=%h expected=%h", v, e.ac); end
    endtask

    task automatic test_store_load();
        regs_t e;
        logic [7:0] v;
        drive(1'b1, B_IRAM, ALU_PASS, 8'h02, 5'b00000, 1'b0, 8'h2A, 8'h00);
        drive(1'b1, B_AC, ALU_HOLD, 8'h80, 5'b00000, 1'b0, 8'h00, 8'h00);
        void'(sb.pop_front());
        e = sb.pop_front();
        checks++; if (dram_addr !== e.ar) begin failures++; $display("FAIL store_ar actual=%h expected=%h", dram_addr, e.ar); end
        bflag = B_AC; cflag = 8'h01;
        #1;
        checks++; if (dram_we !== 1'b1) begin failures++; $display("FAIL store_we actual=%b expected=1", dram_we); end
        checks++; if (dram_wdata !== m.ac) begin failures++; $display("FAIL store_wdata actual=%h expected=%h", dram_wdata, m.ac); end
        checks++; if (dram_addr !== m.ar) begin failures++; $display("FAIL store_addr actual=%h expected=%h", dram_addr, m.ar); end
        drive(1'b1, B_AC, ALU_HOLD, 8'h01, 5'b00000, 1'b0, 8'h00, 8'h00);
        void'(sb.pop_front());
        checks++; if (dram_we !== 1'b0) begin failures++; $display("FAIL idle_we actual=%b expected=0", dram_we); end
        drive(1'b1, B_DRAM, ALU_PASS, 8'h02, 5'b00000, 1'b0, 8'h00, 8'h77);
        e = sb.pop_front();
        peek(B_AC, v);
        checks++; if (v !== e.ac) begin failures++; $display("FAIL load_ac actual=%h expected=%h", v, e.ac); end
    endtask

    task automatic test_conflict();
        regs_t e;
        logic [7:0] v;
        drive(1'b1, B_IRAM, ALU_PASS, 8'h22, 5'b00000, 1'b0, 8'h10, 8'h00);
        drive(1'b1, B_IRAM, ALU_PASS, 8'h02, 5'b00000, 1'b0, 8'h55, 8'h00);
        void'(sb.pop_front()); void'(sb.pop_front());
        drive(1'b1, B_AC, ALU_HOLD, 8'h20, 5'b01000, 1'b0, 8'h00, 8'h00);
        e = sb.pop_front();
        peek(B_R1, v);
        checks++; if (v !== e.r1) begin failures++; $display("FAIL conflict_r1 actual=%h expected=%h", v, e.r1); end
        drive(1'b1, B_ZERO, ALU_HOLD, 8'h00, 5'b01000, 1'b0, 8'h00, 8'h00);
        e = sb.pop_front();
        peek(B_R1, v);
        checks++; if (v !== e.r1) begin failures++; $display("FAIL inc_r1 actual=%h expected=%h", v, e.r1); end
    endtask

    task automatic test_back_to_back();
        regs_t e;
        logic [7:0] v;
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 8'($urandom),
                  5'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
            e = sb.pop_front();
            checks++; if (iram_addr !== e.pc) begin failures++; $display("FAIL b2b_pc[%0d] actual=%h expected=%h", i, iram_addr, e.pc); end
            checks++; if (dram_addr !== e.ar) begin failures++; $display("FAIL b2b_ar[%0d] actual=%h expected=%h", i, dram_addr, e.ar); end
            checks++; if (ir !== e.ir) begin failures++; $display("FAIL b2b_ir[%0d] actual=%h expected=%h", i, ir, e.ir); end
            checks++; if (z !== (e.ac == 8'h00)) begin failures++; $display("FAIL b2b_z[%0d] actual=%b expected=%b", i, z, e.ac == 8'h00); end
            peek(B_R1, v);
            checks++; if (v !== e.r1) begin failures++; $display("FAIL b2b_r1[%0d] actual=%h expected=%h", i, v, e.r1); end
            peek(B_R2, v);
            checks++; if (v !== e.r2) begin failures++; $display("FAIL b2b_r2[%0d] actual=%h expected=%h", i, v, e.r2); end
            peek(B_R3, v);
            checks++; if (v !== e.r3) begin failures++; $display("FAIL b2b_r3[%0d] actual=%h expected=%h", i, v, e.r3); end
            peek(B_R, v);
            checks++; if (v !== e.r) begin failures++; $display("FAIL b2b_r[%0d] actual=%h expected=%h", i, v, e.r); end
            peek(B_AC, v);
            checks++; if (v !== e.ac) begin failures++; $display("FAIL b2b_ac[%0d] actual=%h expected=%h", i, v, e.ac); end
        end
    endtask

    initial begin
        idle();
        iram_data = 8'h00;
        dram_rdata = 8'h00;
        repeat (2) @(negedge clk);
        test_reset();
        test_fetch();
        test_add_sub();
        test_shift();
        test_store_load();
        test_conflict();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
